// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states,
// RISC-V load/store funct3 encodings and the access legality check.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // Load encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // True when the access must be rejected without touching memory:
  // an encoding that does not exist for this direction, or a half/word
  // access that is not naturally aligned.
  function automatic logic access_err(input logic       is_store,
                                      input logic [2:0] f3,
                                      input logic [1:0] addr_lo);
    logic illegal;
    logic misaligned;
    if (is_store) begin
      illegal = !(f3 inside {F3_SB, F3_SH, F3_SW});
    end else begin
      illegal = !(f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    end
    case (f3[1:0])
      2'b01:   misaligned = addr_lo[0];
      2'b10:   misaligned = (addr_lo != 2'b00);
      default: misaligned = 1'b0;
    endcase
    return illegal || misaligned;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: store strobes and lane replication, load lane
// extraction with sign/zero extension. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_lanes,
  output logic [31:0] load_val
);

  // The addressed byte/half is moved down to bit 0 before extension.
  logic [31:0] shifted;
  assign shifted = rdata >> {addr_lo, 3'b000};

  // Size decode: funct3[1:0] selects width, funct3[2] selects unsigned.
  always_comb begin
    wmask       = 4'b1111;
    wdata_lanes = wdata;
    load_val    = rdata;
    case (funct3[1:0])
      2'b00: begin
        wmask       = 4'b0001 << addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
        load_val    = funct3[2] ? {24'd0, shifted[7:0]}
                                : {{24{shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        wmask       = 4'b0011 << addr_lo;
        wdata_lanes = {2{wdata[15:0]}};
        load_val    = funct3[2] ? {16'd0, shifted[15:0]}
                                : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: begin
        wmask       = 4'b1111;
        wdata_lanes = wdata;
        load_val    = rdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one op at a time from the execute stage,
// issues a single word-aligned memory request, waits (with timeout) for
// the response and hands the result to writeback.
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  input  logic        mem_rsp_valid,
  output logic        mem_rsp_ready,
  input  logic [31:0] mem_rsp_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] load_data,
  output logic        out_err
);

  // Counter only needs to reach TIMEOUT-1: the last WAIT cycle is the
  // one where the count equals TIMEOUT-1.
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  state_t       state_reg, state_next;
  logic [31:0]  addr_reg;
  logic [31:0]  wdata_reg;
  logic [2:0]   funct3_reg;
  logic         is_load_reg;
  logic         is_store_reg;
  logic [31:0]  load_data_reg;
  logic         err_reg;
  logic [CW-1:0] count_reg;

  logic         op_err;
  logic         is_mem_op;
  logic [3:0]   align_wmask;
  logic [31:0]  align_wdata;
  logic [31:0]  align_load;

  // A write flag wins over a read flag, so the legality check uses the
  // store rules whenever mem_write is set.
  assign is_mem_op = mem_read || mem_write;
  assign op_err    = is_mem_op && access_err(mem_write, funct3, addr[1:0]);

  lsu_align u_align (
    .funct3      (funct3_reg),
    .addr_lo     (addr_reg[1:0]),
    .wdata       (wdata_reg),
    .rdata       (mem_rsp_rdata),
    .wmask       (align_wmask),
    .wdata_lanes (align_wdata),
    .load_val    (align_load)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next    = state_reg;
    in_ready      = 1'b0;
    mem_req_valid = 1'b0;
    mem_rsp_ready = 1'b0;
    out_valid     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = (is_mem_op && !op_err) ? S_REQ : S_RESP;
        end
      end
      S_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_next = S_WAIT;
      end
      S_WAIT: begin
        mem_rsp_ready = 1'b1;
        if (mem_rsp_valid || (count_reg == LAST)) state_next = S_RESP;
      end
      S_RESP: begin
        out_valid = 1'b1;
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Op capture, response capture and timeout counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg      <= '0;
      wdata_reg     <= '0;
      funct3_reg    <= '0;
      is_load_reg   <= 1'b0;
      is_store_reg  <= 1'b0;
      load_data_reg <= '0;
      err_reg       <= 1'b0;
      count_reg     <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            addr_reg      <= addr;
            wdata_reg     <= wdata;
            funct3_reg    <= funct3;
            is_store_reg  <= mem_write;
            is_load_reg   <= mem_read && !mem_write;
            load_data_reg <= '0;
            err_reg       <= op_err;
            count_reg     <= '0;
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid) begin
            load_data_reg <= is_load_reg ? align_load : 32'd0;
            err_reg       <= 1'b0;
          end else if (count_reg == LAST) begin
            load_data_reg <= '0;
            err_reg       <= 1'b1;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Request fields come straight from the captured op, so they cannot
  // change while the request is stalled. Reads drive no strobes/data.
  assign mem_req_addr  = {addr_reg[31:2], 2'b00};
  assign mem_req_wen   = is_store_reg;
  assign mem_req_wmask = is_store_reg ? align_wmask : 4'b0000;
  assign mem_req_wdata = is_store_reg ? align_wdata : 32'd0;
  assign load_data     = load_data_reg;
  assign out_err       = err_reg;

endmodule
